fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues sequential requests to a 1-cycle-latency synchronous instruction memory. Returned instructions, each paired with its PC+1, are buffered in a small prefetch FIFO. Downstream stalls (IF/ID write disable) and branch/jump redirects are absorbed here, and wrong-path fetches are discarded on redirect.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch front end.
// The prefetch entry pairs a fetched instruction with the address that follows it.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 19
`endif
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 12
`endif

package fetch_pkg;

  typedef struct packed {
    logic [`INSTRUCTION_LEN-1:0] instr;
    logic [`ADDRESS_LEN-1:0]     pc_plus1;
  } fetch_entry_t;

  localparam int FETCH_DEPTH_DEFAULT = 4;
  localparam int FETCH_CNT_W         = $clog2(FETCH_DEPTH_DEFAULT) + 1;

  // Occupancy counters need one extra bit so that a full buffer is representable.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO of arbitrary entry type with a synchronous clear.
// Pushing into a full buffer is illegal and caught by an assertion.
module sync_fifo #(
  parameter type ENTRY_T = logic [7:0],
  parameter int  DEPTH   = 4,
  parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  ENTRY_T           i_wdata,
  input  logic             i_pop,
  output ENTRY_T           o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~o_empty & ~i_clear;
  assign w_push  = i_push & ~i_clear;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; clear wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry storage carries data only, so it is left unreset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_clear && w_full));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and prefetch buffer in front of the IF/ID register.
// Issues sequential reads to a 1-cycle synchronous memory, buffers responses,
// absorbs downstream stalls and flushes wrong-path work on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN lets a response reach out_* in the
// cycle it arrives when the buffer is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH     = FETCH_DEPTH_DEFAULT,
  parameter int INSTR_LEN = `INSTRUCTION_LEN,
  parameter int ADDR_LEN  = `ADDRESS_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic                 imem_req,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] out_instr,
  output logic [ADDR_LEN-1:0]  out_pc_plus1
);

  localparam int CNT_W = fetch_cnt_w(DEPTH);

  logic [ADDR_LEN-1:0] r_fetch_pc;
  logic [ADDR_LEN-1:0] r_inflight_pc1;
  logic                r_inflight;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_occupancy;
  logic                w_fifo_empty;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  fetch_entry_t        w_resp;
  fetch_entry_t        w_head;
  fetch_entry_t        w_out;

  // Space must be reserved for the response still on its way back.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue     = rst & ~redirect_valid & (w_occupancy < (CNT_W+1)'(DEPTH));
  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;

  assign w_resp.instr    = imem_rdata;
  assign w_resp.pc_plus1 = r_inflight_pc1;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = w_fifo_empty & r_inflight;
  assign out_valid = ~w_fifo_empty | w_bypass;
  assign w_out     = w_bypass ? w_resp : (w_fifo_empty ? '0 : w_head);
  // A bypassed response consumed downstream this cycle never lands in the buffer.
  assign w_push    = r_inflight & ~redirect_valid & ~(w_bypass & out_ready);
`else
  assign out_valid = ~w_fifo_empty;
  assign w_out     = w_fifo_empty ? '0 : w_head;
  assign w_push    = r_inflight & ~redirect_valid;
`endif

  assign w_pop        = ~w_fifo_empty & out_ready & ~redirect_valid;
  assign out_instr    = w_out.instr;
  assign out_pc_plus1 = w_out.pc_plus1;

  // Program counter and in-flight tracking; a redirect discards the pending read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc     <= '0;
      r_inflight     <= 1'b0;
      r_inflight_pc1 <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc     <= r_fetch_pc + ADDR_LEN'(1);
        r_inflight_pc1 <= r_fetch_pc + ADDR_LEN'(1);
      end
    end
  end

  sync_fifo #(
    .ENTRY_T (fetch_entry_t),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_resp),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference of the fetch front end.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IL    = 19;
  localparam int AL    = 12;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 2 : 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AL-1:0] redirect_pc = '0;
  logic          imem_req;
  logic [AL-1:0] imem_addr;
  logic [IL-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IL-1:0] out_instr;
  logic [AL-1:0] out_pc_plus1;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_LEN(IL), .ADDR_LEN(AL)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_plus1   (out_pc_plus1)
  );

  function automatic logic [IL-1:0] mem_word(input logic [AL-1:0] a);
    return {{(IL-AL){1'b0}}, a};
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  typedef struct packed {
    logic [IL-1:0] instr;
    logic [AL-1:0] pc1;
  } ent_t;

  ent_t          m_q[$];
  logic [AL-1:0] m_pc;
  bit            m_pend;
  logic [AL-1:0] m_pend_addr;
  bit            e_req;
  bit            e_val;
  ent_t          e_head;

  int n_pass  = 0;
  int n_total = 0;

  bit            o_req;
  bit            o_val;
  logic [AL-1:0] o_addr;
  logic [IL-1:0] o_instr;
  logic [AL-1:0] o_pc1;

  logic [IL-1:0] got_i[$];
  logic [AL-1:0] got_p[$];
  logic [AL-1:0] req_a[$];
  int            first_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = '0;
    m_pend = 1'b0;
    m_pend_addr = '0;
  endtask

  // What the outputs must be right now, from queue contents and the pending read.
  task automatic model_outputs();
    e_req  = rst && !redirect_valid && ((m_q.size() + int'(m_pend)) < DEPTH);
    e_val  = 1'b0;
    e_head = '0;
    if (m_q.size() > 0) begin
      e_val  = 1'b1;
      e_head = m_q[0];
    end else if (BYP && m_pend) begin
      e_val        = 1'b1;
      e_head.instr = mem_word(m_pend_addr);
      e_head.pc1   = AL'(m_pend_addr + 1);
    end
  endtask

  task automatic model_step();
    ent_t r;
    if (redirect_valid) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = redirect_pc;
    end else begin
      if (!BYP && out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_pend) begin
        r.instr = mem_word(m_pend_addr);
        r.pc1   = AL'(m_pend_addr + 1);
        m_q.push_back(r);
      end
      if (BYP && out_ready && m_q.size() > 0) void'(m_q.pop_front());
      m_pend      = e_req;
      m_pend_addr = m_pc;
      if (e_req) m_pc = AL'(m_pc + 1);
    end
  endtask

  // One clock: inputs were driven at the preceding falling edge.
  task automatic step();
    #1;
    model_outputs();
    o_req   = imem_req;
    o_val   = out_valid;
    o_addr  = imem_addr;
    o_instr = out_instr;
    o_pc1   = out_pc_plus1;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(e_val));
    if (e_val) begin
      chk("out_instr", 32'(out_instr), 32'(e_head.instr));
      chk("out_pc_plus1", 32'(out_pc_plus1), 32'(e_head.pc1));
    end
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit rv, input logic [AL-1:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    step();
  endtask

  task automatic run_collect(input int n, input bit rdy);
    got_i.delete();
    got_p.delete();
    req_a.delete();
    first_v = 0;
    for (int k = 1; k <= n; k++) begin
      drive(1'b0, '0, rdy);
      if (o_val && first_v == 0) first_v = k;
      if (o_val && rdy) begin
        got_i.push_back(o_instr);
        got_p.push_back(o_pc1);
      end
      if (o_req) req_a.push_back(o_addr);
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; released at a falling edge.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'd0);
    chk("rst_out_pc_plus1", 32'(out_pc_plus1), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int nacc;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming from reset with downstream always ready.
    run_collect(8, 1'b1);
    chk("A_first_valid_cycle", 32'(first_v), 32'(LAT));
    chk("A_enough_outputs", 32'(got_i.size() >= 3), 32'd1);
    chk("A_addr0", 32'(req_a[0]), 32'h000);
    chk("A_addr1", 32'(req_a[1]), 32'h001);
    chk("A_addr2", 32'(req_a[2]), 32'h002);
    for (int i = 0; i < 3; i++) begin
      chk("A_instr", 32'(got_i[i]), 32'(i));
      chk("A_pc1", 32'(got_p[i]), 32'(i + 1));
    end

    // Stall for ten cycles, then drain.
    do_reset();
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b0);
      if (o_req) nacc++;
    end
    chk("B_accepted_reqs", 32'(nacc), 32'd4);
    chk("B_req_dropped", 32'(o_req), 32'd0);
    run_collect(8, 1'b1);
    chk("B_enough_outputs", 32'(got_i.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("B_drain_order", 32'(got_i[i]), 32'(i));

    // Redirect with three entries queued and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0);
    drive(1'b1, 12'h100, 1'b1);
    run_collect(8, 1'b1);
    chk("C_first_req_addr", 32'(req_a[0]), 32'h100);
    chk("C_redirect_latency", 32'(first_v), 32'(LAT));
    chk("C_first_instr", 32'(got_i[0]), 32'h100);
    chk("C_first_pc1", 32'(got_p[0]), 32'h101);
    chk("C_second_instr", 32'(got_i[1]), 32'h101);

    // Back-to-back redirects: the later one wins.
    drive(1'b1, 12'h050, 1'b1);
    drive(1'b1, 12'h0A0, 1'b1);
    run_collect(8, 1'b1);
    chk("D_first_instr", 32'(got_i[0]), 32'h0A0);
    chk("D_first_pc1", 32'(got_p[0]), 32'h0A1);
    chk("D_second_instr", 32'(got_i[1]), 32'h0A1);

    // Address wrap at the top of the space.
    drive(1'b1, 12'hFFE, 1'b1);
    run_collect(8, 1'b1);
    chk("E_pc1_0", 32'(got_p[0]), 32'hFFF);
    chk("E_pc1_1", 32'(got_p[1]), 32'h000);
    chk("E_pc1_2", 32'(got_p[2]), 32'h001);
    chk("E_addr_wrap", 32'(req_a[2]), 32'h000);

    // Reset with two entries queued, then fetch restarts at zero.
    drive(1'b1, 12'h200, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0);
    chk("F_two_queued_visible", 32'(out_valid), 32'd1);
    do_reset();
    drive(1'b0, '0, 1'b1);
    chk("F_restart_req", 32'(o_req), 32'd1);
    chk("F_restart_addr", 32'(o_addr), 32'h000);

    // Randomized traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        logic [AL-1:0] rpc;
        rpc = ($urandom_range(0, 3) == 0) ? AL'(12'hFFC + $urandom_range(0, 3)) : AL'($urandom);
        drive($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
